// File: rtl/cmd_receiver.sv
// Remote command link endpoint: deserialises 3-byte {cmd,data} frames from the UART
// and sends single response bytes back.

module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV);
  logic [1:0]    rx_sync;
  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          rx_s;

  assign rx_s = rx_sync[1];

  // Samples land mid-bit: half a bit after the start edge, then every full bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rdy      <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (clr_rdy) rdy <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy     <= 1'b1;
          baud_cnt <= BW'(BAUD_DIV / 2);
          bit_cnt  <= '0;
        end
      end else if (baud_cnt == '0) begin
        shreg    <= {rx_s, shreg[9:1]};
        baud_cnt <= BW'(BAUD_DIV - 1);
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          rdy     <= 1'b1;
          rx_data <= shreg[9:2];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - BW'(1);
      end
    end
  end
endmodule

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV);
  logic          busy;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!busy) begin
        if (trmt) begin
          busy     <= 1'b1;
          shreg    <= {1'b1, tx_data, 1'b0};
          baud_cnt <= BW'(BAUD_DIV - 1);
          bit_cnt  <= '0;
        end
      end else if (baud_cnt == '0) begin
        baud_cnt <= BW'(BAUD_DIV - 1);
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          shreg   <= {1'b1, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - BW'(1);
      end
    end
  end

  assign tx = busy ? shreg[0] : 1'b1;
endmodule

module uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(RX), .clr_rdy(clr_rx_rdy), .rdy(rx_rdy), .rx_data(rx_data)
  );
  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .tx(TX), .tx_done(tx_done)
  );
endmodule

module cmd_receiver #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int BAUD_DIV    = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_busy,
  output logic        resp_sent
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} rx_st_t;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] hi;
  } stage_t;

  rx_st_t        state, nxt;
  stage_t        stage;
  logic [TW-1:0] tmo_cnt;
  logic          rx_rdy, clr_rx_rdy, tx_done, trmt;
  logic [7:0]    rx_data, resp_q;
  logic          cap_cmd, cap_hi, complete, tmo, tmo_clr, tmo_hit;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst_n(~rst), .RX(RX), .TX(TX),
    .clr_rx_rdy(clr_rx_rdy), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .trmt(trmt), .tx_data(resp_q), .tx_done(tx_done)
  );

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    clr_rx_rdy = 1'b0;
    cap_cmd    = 1'b0;
    cap_hi     = 1'b0;
    complete   = 1'b0;
    tmo        = 1'b0;
    tmo_clr    = 1'b0;
    case (state)
      IDLE: begin
        tmo_clr = 1'b1;
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          cap_cmd    = 1'b1;
          nxt        = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          cap_hi     = 1'b1;
          tmo_clr    = 1'b1;
          nxt        = WAIT_LO;
        end else if (tmo_hit) begin
          tmo = 1'b1;
          nxt = IDLE;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          complete   = 1'b1;
          tmo_clr    = 1'b1;
          nxt        = IDLE;
        end else if (tmo_hit) begin
          tmo = 1'b1;
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // cmd/data only move at completion so the core sees a stable command while cmd_rdy=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage     <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      data      <= '0;
      cmd_rdy   <= 1'b0;
      cmd_ovr   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= tmo;
      if (tmo_clr || tmo) tmo_cnt <= '0;
      else                tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo)          stage    <= '0;
      else if (cap_cmd) stage.cmd <= rx_data;
      else if (cap_hi)  stage.hi  <= rx_data;
      if (complete) begin
        cmd     <= stage.cmd;
        data    <= {stage.hi, rx_data};
        cmd_rdy <= 1'b1;
        cmd_ovr <= clr_cmd_rdy ? 1'b0 : (cmd_ovr | cmd_rdy);
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        cmd_ovr <= 1'b0;
      end
    end
  end

  // Response path: one byte at a time, requests while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q    <= '0;
      trmt      <= 1'b0;
      resp_busy <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      if (send_resp && !resp_busy) begin
        resp_q    <= resp;
        trmt      <= 1'b1;
        resp_busy <= 1'b1;
      end else if (tx_done) begin
        resp_busy <= 1'b0;
        resp_sent <= 1'b1;
      end
    end
  end
endmodule
